// File: rtl/dll_lcrc_framer.sv
// DLL framer: 16-bit sequence header beat, payload passthrough, then LCRC trailer beat.
// Optional build macro LCRC_NULLIFY_EN adds in_nullify for nullified TLPs (raw CRC, no seq advance).
module dll_lcrc_framer #(
    parameter int               DATA_W   = 32,
    parameter int               SEQ_W    = 12,
    parameter logic [SEQ_W-1:0] SEQ_INIT = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seq_clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sop,
    input  logic              in_eop,
`ifdef LCRC_NULLIFY_EN
    input  logic              in_nullify,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic [SEQ_W-1:0]  seq_o,
    output logic [1:0]        o_dbg_state
);

    // Handshake: a beat moves on a rising edge where valid && ready; a presented
    // output beat holds data/sop/eop unchanged until it is taken.
    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_CRC} state_t;

    function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic b);
        logic [31:0] s;
        s = {c[30:0], 1'b0};
        return (c[31] ^ b) ? (s ^ CRC_POLY) : s;
    endfunction

    function automatic logic [31:0] crc_hdr(input logic [15:0] d);
        logic [31:0] c;
        c = CRC_INIT;
        for (int i = 15; i >= 0; i--) c = crc_bit(c, d[i]);
        return c;
    endfunction

    function automatic logic [31:0] crc_beat(input logic [31:0] c0, input logic [DATA_W-1:0] d);
        logic [31:0] c;
        c = c0;
        for (int i = DATA_W - 1; i >= 0; i--) c = crc_bit(c, d[i]);
        return c;
    endfunction

    state_t              r_state;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_sop;
    logic                r_out_eop;
    logic [SEQ_W-1:0]    r_seq;
    logic [31:0]         r_crc;
    logic                r_nul;
    logic                r_clr_pend;

    state_t              w_next;
    logic                w_slot_free;
    logic                w_in_ready;
    logic                w_load;
    logic [DATA_W-1:0]   w_load_data;
    logic                w_load_sop;
    logic                w_load_eop;
    logic [SEQ_W-1:0]    w_seq_next;
    logic [31:0]         w_crc_next;
    logic                w_nul_next;
    logic                w_clr_next;
    logic [15:0]         w_seq_field;
    logic                w_nul_in;
    logic [DATA_W-1:0]   w_hdr;
    logic [DATA_W-1:0]   w_trl;

`ifdef LCRC_NULLIFY_EN
    assign w_nul_in = in_nullify;
`else
    assign w_nul_in = 1'b0;
`endif

    assign w_slot_free = !r_out_valid || out_ready;
    assign w_seq_field = 16'(r_seq);

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_load      = 1'b0;
        w_load_data = '0;
        w_load_sop  = 1'b0;
        w_load_eop  = 1'b0;
        w_seq_next  = r_seq;
        w_crc_next  = r_crc;
        w_nul_next  = r_nul;
        w_clr_next  = r_clr_pend;
        w_hdr       = '0;
        w_hdr[15:0] = w_seq_field;
        w_trl       = '0;
        w_trl[31:0] = r_nul ? r_crc : ~r_crc;
        case (r_state)
            S_IDLE: begin
                if (seq_clr) w_seq_next = SEQ_INIT;
                if (in_valid && in_sop) begin
                    // The sop beat stays on the input; it is consumed in DATA.
                    if (w_slot_free) begin
                        w_load      = 1'b1;
                        w_load_data = w_hdr;
                        w_load_sop  = 1'b1;
                        w_crc_next  = crc_hdr(w_seq_field);
                        w_clr_next  = seq_clr;
                        w_nul_next  = 1'b0;
                        w_next      = S_DATA;
                    end
                end else if (in_valid) begin
                    w_in_ready = 1'b1;
                end
            end
            S_DATA: begin
                w_in_ready = w_slot_free;
                if (in_valid && w_slot_free) begin
                    w_load      = 1'b1;
                    w_load_data = in_data;
                    w_crc_next  = crc_beat(r_crc, in_data);
                    if (in_eop) begin
                        w_nul_next = w_nul_in;
                        w_next     = S_CRC;
                    end
                end
            end
            S_CRC: begin
                if (w_slot_free) begin
                    w_load      = 1'b1;
                    w_load_data = w_trl;
                    w_load_eop  = 1'b1;
                    // A clear taken with the header already set the counter; it stays put.
                    if (!r_clr_pend && !r_nul) w_seq_next = r_seq + SEQ_W'(1);
                    w_crc_next  = CRC_INIT;
                    w_clr_next  = 1'b0;
                    w_nul_next  = 1'b0;
                    w_next      = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_seq       <= SEQ_INIT;
            r_crc       <= CRC_INIT;
            r_nul       <= 1'b0;
            r_clr_pend  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_seq      <= w_seq_next;
            r_crc      <= w_crc_next;
            r_nul      <= w_nul_next;
            r_clr_pend <= w_clr_next;
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_load_data;
                r_out_sop   <= w_load_sop;
                r_out_eop   <= w_load_eop;
            end else if (w_slot_free) begin
                r_out_valid <= 1'b0;
                r_out_sop   <= 1'b0;
                r_out_eop   <= 1'b0;
            end
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_sop     = r_out_sop;
    assign out_eop     = r_out_eop;
    assign seq_o       = r_seq;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dll_lcrc_framer.sv
// Bench for dll_lcrc_framer: queued expected frames from a bit-serial LCRC model, negedge monitor.
`timescale 1ns/1ps
module tb_dll_lcrc_framer;
  localparam int DW = 32;
  localparam int SW = 12;
  localparam logic [31:0] POLY = 32'h04C1_1DB7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic seq_clr = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [DW-1:0] in_data = '0;
  logic in_sop = 1'b0;
  logic in_eop = 1'b0;
`ifdef LCRC_NULLIFY_EN
  logic in_nullify = 1'b0;
`endif
  logic out_valid;
  logic out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic out_sop;
  logic out_eop;
  logic [SW-1:0] seq_o;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  bit stall_en = 1'b0;
  logic [DW+1:0] exp_q[$];
  logic [DW-1:0] pay_q[$];
  logic [SW-1:0] m_seq = '0;
  logic [DW+1:0] mon_e;

  dll_lcrc_framer #(.DATA_W(DW), .SEQ_W(SW), .SEQ_INIT('0)) dut (
    .clk(clk), .rst(rst), .seq_clr(seq_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop),
`ifdef LCRC_NULLIFY_EN
    .in_nullify(in_nullify),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop), .seq_o(seq_o), .o_dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor: a beat is taken on the next posedge when valid && ready here
  always @(negedge clk) begin
    if (mon_en && rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got %h expected none", {out_sop, out_eop, out_data});
      end else begin
        mon_e = exp_q.pop_front();
        check("out_beat", 64'({out_sop, out_eop, out_data}), 64'(mon_e));
      end
    end
  end

  // reference model: LCRC over the 16-bit field then payload as one MSB-first bit stream
  task automatic expect_tlp(input bit nul, input bit clr);
    bit bits[$];
    logic [15:0] f;
    logic [31:0] c;
    f = 16'(m_seq);
    for (int i = 15; i >= 0; i--) bits.push_back(f[i]);
    foreach (pay_q[k]) for (int i = DW - 1; i >= 0; i--) bits.push_back(pay_q[k][i]);
    c = 32'hFFFF_FFFF;
    foreach (bits[j]) c = (c[31] ^ bits[j]) ? ((c << 1) ^ POLY) : (c << 1);
    exp_q.push_back({1'b1, 1'b0, DW'(f)});
    foreach (pay_q[k]) exp_q.push_back({2'b00, pay_q[k]});
    exp_q.push_back({1'b0, 1'b1, DW'(nul ? c : ~c)});
    if (clr) m_seq = '0;
    else if (!nul) m_seq = SW'((int'(m_seq) + 1) % (1 << SW));
  endtask

  task automatic drive_beat(input logic [DW-1:0] d, input bit sop, input bit eop, input bit clr, input bit nul);
    bit got;
    int budget;
    got = 1'b0;
    budget = 0;
    in_valid = 1'b1;
    in_data = d;
    in_sop = sop;
    in_eop = eop;
    seq_clr = clr;
`ifdef LCRC_NULLIFY_EN
    in_nullify = nul;
`endif
    while (!got && budget < 1000) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    seq_clr = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL beat_accept_timeout: got no accept expected accept within %0d cycles", budget);
    end
  endtask

  task automatic send_tlp(input bit nul, input bit clr);
    int n;
    n = pay_q.size();
    expect_tlp(nul, clr);
    for (int k = 0; k < n; k++)
      drive_beat(pay_q[k], k == 0, k == n - 1, clr && k == 0, nul && k == n - 1);
    in_valid = 1'b0;
    in_sop = 1'b0;
    in_eop = 1'b0;
  endtask

  task automatic rand_payload(input int n);
    pay_q.delete();
    for (int k = 0; k < n; k++) pay_q.push_back(DW'($urandom));
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 4000) begin
      @(posedge clk);
      b++;
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_data"}, 64'(out_data), 64'd0);
    check({tag, "_out_sop"}, 64'(out_sop), 64'd0);
    check({tag, "_out_eop"}, 64'(out_eop), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_seq_o"}, 64'(seq_o), 64'd0);
  endtask

  initial begin
    int c0;
    // 1) reset
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // 2) fixed 3-beat TLP
    pay_q.delete();
    pay_q.push_back(32'h1234_5678);
    pay_q.push_back(32'h9abc_deff);
    pay_q.push_back(32'hfff1_2345);
    send_tlp(1'b0, 1'b0);
    drain();
    check("seq_after_fixed", 64'(seq_o), 64'd1);

    // beat without sop in IDLE is dropped, state untouched
    in_valid = 1'b1;
    in_sop = 1'b0;
    in_data = DW'($urandom);
    @(negedge clk);
    check("drop_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("drop_no_output", 64'(out_valid), 64'd0);
    check("drop_seq", 64'(seq_o), 64'(m_seq));
    rand_payload(2);
    send_tlp(1'b0, 1'b0);
    drain();

    // seq_clr with header load: header uses old seq, counter ends at init
    rand_payload(2);
    send_tlp(1'b0, 1'b1);
    drain();
    check("seq_after_clr_frame", 64'(seq_o), 64'd0);
    rand_payload(1);
    send_tlp(1'b0, 1'b0);
    drain();
    seq_clr = 1'b1;
    @(posedge clk);
    #1;
    seq_clr = 1'b0;
    m_seq = '0;
    check("seq_after_idle_clr", 64'(seq_o), 64'd0);

    // 3) 4096 back-to-back 1-beat TLPs, no bubbles, seq wraps
    c0 = cyc;
    for (int t = 0; t < 4096; t++) begin
      rand_payload(1);
      send_tlp(1'b0, 1'b0);
    end
    check("b2b_cycles", 64'(cyc - c0), 64'(3 * 4096 - 1));
    drain();
    check("seq_wrapped", 64'(seq_o), 64'd0);

    // 4) random backpressure on an 8-beat TLP and a few random-length TLPs
    stall_en = 1'b1;
    rand_payload(8);
    send_tlp(1'b0, 1'b0);
    for (int t = 0; t < 6; t++) begin
      rand_payload($urandom_range(1, 6));
      send_tlp(1'b0, 1'b0);
    end
    drain();
    stall_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("seq_after_stall", 64'(seq_o), 64'(m_seq));

    // 5) reset during beat 2 of a 4-beat TLP
    mon_en = 1'b0;
    exp_q.delete();
    rand_payload(4);
    drive_beat(pay_q[0], 1'b1, 1'b0, 1'b0, 1'b0);
    drive_beat(pay_q[1], 1'b0, 1'b0, 1'b0, 1'b0);
    in_data = pay_q[2];
    #2;
    rst = 1'b0;
    in_valid = 1'b0;
    in_sop = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    m_seq = '0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    rand_payload(4);
    send_tlp(1'b0, 1'b0);
    drain();
    check("seq_after_midrst", 64'(seq_o), 64'd1);

`ifdef LCRC_NULLIFY_EN
    // 6) nullified TLP: raw CRC trailer, sequence reused
    rand_payload(3);
    send_tlp(1'b1, 1'b0);
    drain();
    check("seq_after_nullify", 64'(seq_o), 64'd1);
    rand_payload(2);
    send_tlp(1'b0, 1'b0);
    drain();
    check("seq_after_reuse", 64'(seq_o), 64'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    errors++;
    checks++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end
endmodule
